// File: rtl/sym_serializer.sv
// ---------------------------------------------------------------------------
// sym_serializer
//   Parallel-to-serial front end for the symbol recognisers (a=0, b=1).
//   Takes a word of up to WIDTH symbols over a valid/ready handshake and
//   emits it MSB-first (load_data[len-1] first, load_data[0] last), one
//   symbol per clock, on bit_out/bit_valid. A new word can be accepted
//   while the last symbol of the current word is on the output, so words
//   stream back to back with no gap.
//
// Handshake: a word transfers at a posedge where load_valid && load_ready.
//   load_data/load_len are sampled only at that edge. load_ready is
//   combinational: high in IDLE, high in SHIFT only while the last symbol
//   is on the output (count==1), and always low while flush or reset is
//   asserted. Upstream holds the word stable while load_ready is low.
//
// Ports
//   clock       in   1      posedge-active clock
//   reset_n     in   1      asynchronous active-low reset
//   load_valid  in   1      upstream word present
//   load_ready  out  1      serializer accepts a word this cycle
//   load_data   in   WIDTH  symbols of the word
//   load_len    in   LEN_W  symbols to send (0..WIDTH, larger is clamped)
//   flush       in   1      synchronous abort of the word in flight
//   bit_out     out  1      current symbol (registered)
//   bit_valid   out  1      bit_out carries a real symbol
//   bit_last    out  1      bit_out is the final symbol of its word
//   busy        out  1      FSM is in SHIFT (exposes the FSM state)
// ---------------------------------------------------------------------------
module sym_serializer #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic [LEN_W-1:0] load_len,
    input  logic             flush,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             bit_last,
    output logic             busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;    // symbols still to send, next one at MSB
    logic [LEN_W-1:0] count;    // symbols of the word not yet retired, incl. the one on bit_out

    logic             transfer;
    logic [LEN_W-1:0] eff_len;
    logic [LEN_W-1:0] shamt;
    logic [WIDTH-1:0] aligned;

    always_comb begin
        load_ready = reset_n && !flush &&
                     ((state == IDLE) || (count == LEN_W'(1)));
        transfer   = load_valid && load_ready;
        eff_len    = (load_len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : load_len;
        // Left-justify the word so its first symbol (data[len-1]) sits at
        // the MSB; unused upper bits of a short word fall off the top.
        shamt      = LEN_W'(WIDTH) - eff_len;
        aligned    = load_data << shamt;
    end

    assign busy = (state == SHIFT);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            shreg     <= '0;
            count     <= '0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            bit_last  <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            shreg     <= '0;
            count     <= '0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            bit_last  <= 1'b0;
        end else if (transfer && (eff_len != '0)) begin
            // Load from IDLE or reload on the last symbol: first symbol
            // goes straight to the output register, the rest into shreg.
            state     <= SHIFT;
            bit_out   <= aligned[WIDTH-1];
            shreg     <= {aligned[WIDTH-2:0], 1'b0};
            count     <= eff_len;
            bit_valid <= 1'b1;
            bit_last  <= (eff_len == LEN_W'(1));
        end else if ((state == SHIFT) && (count > LEN_W'(1))) begin
            bit_out   <= shreg[WIDTH-1];
            shreg     <= {shreg[WIDTH-2:0], 1'b0};
            count     <= count - LEN_W'(1);
            bit_valid <= 1'b1;
            bit_last  <= (count == LEN_W'(2));
        end else begin
            // Idle, last symbol retired with no new word, or a len==0 word
            // consumed: nothing to emit next cycle.
            state     <= IDLE;
            shreg     <= '0;
            count     <= '0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            bit_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sym_serializer.sv
// ---------------------------------------------------------------------------
// tb_sym_serializer
//   Directed, table-driven bench for sym_serializer (WIDTH=8, LEN_W=4).
//   Each table row gives the inputs for one cycle, the expected load_ready
//   in that cycle, and the expected registered outputs after the edge.
//   A stream monitor also checks every valid symbol against an expected
//   queue. Reset-in-flight is a hand-written sequence.
// ---------------------------------------------------------------------------
module tb_sym_serializer;

    localparam int WIDTH = 8;
    localparam int LEN_W = 4;

    // ---------------- clock / reset ----------------
    logic             clock;
    logic             reset_n;
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic [LEN_W-1:0] load_len;
    logic             flush;
    logic             bit_out;
    logic             bit_valid;
    logic             bit_last;
    logic             busy;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    sym_serializer #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_len   (load_len),
        .flush      (flush),
        .bit_out    (bit_out),
        .bit_valid  (bit_valid),
        .bit_last   (bit_last),
        .busy       (busy)
    );

    // ---------------- scoreboard ----------------
    int         checks = 0;
    int         errors = 0;
    logic [0:0] exp_q[$];

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
        end
    endtask

    // Stream monitor: every valid symbol must match the next expected one.
    always @(negedge clock) begin
        if (reset_n === 1'b1 && bit_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stream_extra actual=%b expected=none t=%0t", bit_out, $time);
            end else begin
                logic [0:0] e;
                e = exp_q.pop_front();
                check("stream_sym", bit_out, e);
            end
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0]       flags;   // {load_valid, flush}
        logic [WIDTH-1:0] data;
        logic [LEN_W-1:0] len;
        logic [3:0]       exp;     // {load_ready, bit_out, bit_valid, bit_last}
    } vec_t;

    vec_t vecs[64];
    int   n_vec = 0;

    task automatic add_vec(input logic [1:0] flags, input logic [WIDTH-1:0] data,
                           input logic [LEN_W-1:0] len, input logic [3:0] exp);
        vecs[n_vec].flags = flags;
        vecs[n_vec].data  = data;
        vecs[n_vec].len   = len;
        vecs[n_vec].exp   = exp;
        n_vec++;
    endtask

    // ---------------- driver ----------------
    // Called at a negedge; returns at the next negedge.
    task automatic run_row(input int i);
        load_valid = vecs[i].flags[1];
        flush      = vecs[i].flags[0];
        load_data  = vecs[i].data;
        load_len   = vecs[i].len;
        #1;
        check($sformatf("row%0d_ready", i), load_ready, vecs[i].exp[3]);
        @(posedge clock);
        #1;
        check($sformatf("row%0d_out", i),   bit_out,   vecs[i].exp[2]);
        check($sformatf("row%0d_valid", i), bit_valid, vecs[i].exp[1]);
        check($sformatf("row%0d_last", i),  bit_last,  vecs[i].exp[0]);
        check($sformatf("row%0d_busy", i),  busy,      vecs[i].exp[1]);
        if (vecs[i].exp[1]) exp_q.push_back(vecs[i].exp[2]);
        @(negedge clock);
    endtask

    initial begin
        reset_n    = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        load_len   = '0;
        flush      = 1'b0;

        // abaababb: 8 symbols, last flag on the 8th only
        add_vec(2'b10, 8'h4B, 4'd8, 4'b1010);
        add_vec(2'b00, 8'h00, 4'd0, 4'b0110);
        add_vec(2'b00, 8'h00, 4'd0, 4'b0010);
        add_vec(2'b00, 8'h00, 4'd0, 4'b0010);
        add_vec(2'b00, 8'h00, 4'd0, 4'b0110);
        add_vec(2'b00, 8'h00, 4'd0, 4'b0010);
        add_vec(2'b00, 8'h00, 4'd0, 4'b0110);
        add_vec(2'b00, 8'h00, 4'd0, 4'b0111);
        add_vec(2'b00, 8'h00, 4'd0, 4'b1000);
        // 0101 then 101 back to back; held-off words with junk are ignored
        add_vec(2'b10, 8'h05, 4'd4, 4'b1010);
        add_vec(2'b10, 8'hFF, 4'd8, 4'b0110);
        add_vec(2'b10, 8'h00, 4'd1, 4'b0010);
        add_vec(2'b10, 8'hAA, 4'd2, 4'b0111);
        add_vec(2'b10, 8'h05, 4'd3, 4'b1110);
        add_vec(2'b00, 8'h00, 4'd0, 4'b0010);
        add_vec(2'b00, 8'h00, 4'd0, 4'b0111);
        add_vec(2'b00, 8'h00, 4'd0, 4'b1000);
        // len=0 consumed silently
        add_vec(2'b10, 8'hFF, 4'd0, 4'b1000);
        add_vec(2'b00, 8'h00, 4'd0, 4'b1000);
        // len=12 clamps to 8: 10100101
        add_vec(2'b10, 8'hA5, 4'd12, 4'b1110);
        add_vec(2'b00, 8'h00, 4'd0, 4'b0010);
        add_vec(2'b00, 8'h00, 4'd0, 4'b0110);
        add_vec(2'b00, 8'h00, 4'd0, 4'b0010);
        add_vec(2'b00, 8'h00, 4'd0, 4'b0010);
        add_vec(2'b00, 8'h00, 4'd0, 4'b0110);
        add_vec(2'b00, 8'h00, 4'd0, 4'b0010);
        add_vec(2'b00, 8'h00, 4'd0, 4'b0111);
        add_vec(2'b00, 8'h00, 4'd0, 4'b1000);
        // len=1: first symbol is also last
        add_vec(2'b10, 8'h01, 4'd1, 4'b1111);
        add_vec(2'b00, 8'h00, 4'd0, 4'b1000);
        // len=2, then a len=0 word accepted on the last symbol -> idle
        add_vec(2'b10, 8'h02, 4'd2, 4'b1110);
        add_vec(2'b00, 8'h00, 4'd0, 4'b0011);
        add_vec(2'b10, 8'hFF, 4'd0, 4'b1000);
        add_vec(2'b00, 8'h00, 4'd0, 4'b1000);
        // 10110 flushed during symbol 2; pending word accepted next edge
        add_vec(2'b10, 8'h16, 4'd5, 4'b1110);
        add_vec(2'b00, 8'h00, 4'd0, 4'b0010);
        add_vec(2'b11, 8'h03, 4'd2, 4'b0000);
        add_vec(2'b10, 8'h03, 4'd2, 4'b1110);
        add_vec(2'b00, 8'h00, 4'd0, 4'b0111);
        add_vec(2'b00, 8'h00, 4'd0, 4'b1000);

        // ---- reset state ----
        repeat (3) @(negedge clock);
        check("rst_out",   bit_out,    1'b0);
        check("rst_valid", bit_valid,  1'b0);
        check("rst_last",  bit_last,   1'b0);
        check("rst_busy",  busy,       1'b0);
        check("rst_ready", load_ready, 1'b0);
        reset_n = 1'b1;
        #1;
        check("rel_ready", load_ready, 1'b1);
        @(negedge clock);

        // ---- table ----
        for (int i = 0; i < n_vec; i++) run_row(i);

        // ---- reset mid-word after 3 of 8 symbols ----
        load_valid = 1'b1;
        load_data  = 8'hFF;
        load_len   = 4'd8;
        repeat (3) exp_q.push_back(1'b1);
        @(negedge clock);          // symbol 1 seen by monitor
        load_valid = 1'b0;
        load_data  = '0;
        load_len   = '0;
        @(negedge clock);          // symbol 2
        @(negedge clock);          // symbol 3
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_out",   bit_out,    1'b0);
        check("midrst_valid", bit_valid,  1'b0);
        check("midrst_last",  bit_last,   1'b0);
        check("midrst_busy",  busy,       1'b0);
        check("midrst_ready", load_ready, 1'b0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("midrel_ready", load_ready, 1'b1);
        for (int c = 0; c < 10; c++) begin
            @(posedge clock);
            #1;
            check($sformatf("midrel_valid%0d", c), bit_valid, 1'b0);
        end
        @(negedge clock);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL stream_drained actual=%0d expected=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
